axi_lite_counter_slave: RTL and testbench

// - AXI4-Lite slave peripheral of the AXI_counter IP: 4 x 32-bit register file plus a prescaled up/down counter engine.
// - Sits directly downstream of the PS/VIP AXI4-Lite master; software configures, starts, loads and reads the counter.
// - Optional level interrupt on compare match.

---
 rtl/axi_lite_counter_slave_if.sv | 39 +++
 rtl/axi_lite_counter_slave.sv | 209 ++++++++++++++++++++
 tb/tb_axi_lite_counter_slave.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_counter_slave_if.sv
// AXI4-Lite bus bundle between the PS/VIP master and the counter slave.
// Latency: none, wires only.
// Backpressure: carries the standard valid/ready pairs of all five channels.
interface axi_lite_counter_slave_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_counter_slave.sv
// AXI4-Lite slave: CTRL/LOAD/COMPARE/COUNT registers driving a prescaled up/down counter.
// Latency: write accepted 1 cycle after AW+W valid, B the cycle after; R valid 2 cycles after AR valid.
// Backpressure: one write and one read outstanding; held B/R blocks further AW/W or AR acceptance.
// Optional feature macro: AXI_COUNTER_IRQ_EN adds the irq port and CTRL bit9 IRQ_EN.
module axi_lite_counter_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_CNT_WIDTH        = 32,
    parameter int C_PRESCALE         = 0
) (
    input  logic                      s00_axi_aclk,
    input  logic                      s00_axi_aresetn,
    axi_lite_counter_slave_if.slave   s00_axi
`ifdef AXI_COUNTER_IRQ_EN
    ,
    output logic                      irq
`endif
);

    localparam logic [31:0]            PRESC_LAST = 32'(C_PRESCALE);
    localparam logic [C_CNT_WIDTH-1:0] CNT_ONE    = C_CNT_WIDTH'(1);

    logic                   wr_fire;
    logic                   rd_fire;
    logic [1:0]             wr_sel;
    logic [1:0]             rd_sel;
    logic                   ctrl_wr;
    logic                   do_clr;
    logic                   do_load;
    logic                   w1c;
    logic                   tick;
    logic                   match_hit;

    logic                   ctl_en;
    logic                   ctl_dir;
    logic                   ctl_auto;
    logic                   ctl_match;
    logic                   ctl_irq_en;
    logic [C_CNT_WIDTH-1:0] load_q;
    logic [C_CNT_WIDTH-1:0] cmp_q;
    logic [C_CNT_WIDTH-1:0] count_q;
    logic [C_CNT_WIDTH-1:0] count_step;
    logic [31:0]            presc_q;

    logic [31:0]            load_wide;
    logic [31:0]            cmp_wide;
    logic [31:0]            count_wide;
    logic [31:0]            ctrl_rd;
    logic [31:0]            load_merged;
    logic [31:0]            cmp_merged;
    logic [31:0]            rd_mux;
    logic                   unused_ok;

    // Byte-enable merge of new write data over an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign wr_fire = s00_axi.awready & s00_axi.awvalid & s00_axi.wready & s00_axi.wvalid;
    assign rd_fire = s00_axi.arready & s00_axi.arvalid;
    assign wr_sel  = s00_axi.awaddr[3:2];
    assign rd_sel  = s00_axi.araddr[3:2];

    assign s00_axi.bresp = 2'b00;
    assign s00_axi.rresp = 2'b00;

    // Protection bits and the byte offset inside a word carry no meaning here.
    assign unused_ok = ^{s00_axi.awprot, s00_axi.arprot,
                         s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

    // Zero-extend the counter-width registers to the 32-bit bus and build the CTRL view.
    always_comb begin
        load_wide                    = '0;
        cmp_wide                     = '0;
        count_wide                   = '0;
        load_wide[C_CNT_WIDTH-1:0]   = load_q;
        cmp_wide[C_CNT_WIDTH-1:0]    = cmp_q;
        count_wide[C_CNT_WIDTH-1:0]  = count_q;
        ctrl_rd                      = '0;
        ctrl_rd[0]                   = ctl_en;
        ctrl_rd[1]                   = ctl_dir;
        ctrl_rd[2]                   = ctl_auto;
        ctrl_rd[8]                   = ctl_match;
`ifdef AXI_COUNTER_IRQ_EN
        ctrl_rd[9]                   = ctl_irq_en;
`endif
        load_merged = merge_bytes(load_wide, s00_axi.wdata, s00_axi.wstrb);
        cmp_merged  = merge_bytes(cmp_wide,  s00_axi.wdata, s00_axi.wstrb);
    end

    // Read mux; COUNT returns the value held before this cycle's counter update.
    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0:    rd_mux = ctrl_rd;
            2'd1:    rd_mux = load_wide;
            2'd2:    rd_mux = cmp_wide;
            default: rd_mux = count_wide;
        endcase
    end

    // Decode CTRL side effects and the counter tick; CLR beats LOAD_NOW beats tick.
    always_comb begin
        ctrl_wr    = wr_fire && (wr_sel == 2'd0);
        do_clr     = ctrl_wr && s00_axi.wstrb[0] && s00_axi.wdata[3];
        do_load    = ctrl_wr && s00_axi.wstrb[0] && s00_axi.wdata[4] && !do_clr;
        w1c        = ctrl_wr && s00_axi.wstrb[1] && s00_axi.wdata[8];
        tick       = ctl_en && (presc_q == PRESC_LAST) && !do_clr && !do_load;
        match_hit  = tick && (count_q == cmp_q);
        count_step = ctl_dir ? (count_q - CNT_ONE) : (count_q + CNT_ONE);
    end

    // AXI handshakes: one-cycle ready pulses, responses held until accepted.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            s00_axi.awready <= 1'b0;
            s00_axi.wready  <= 1'b0;
            s00_axi.bvalid  <= 1'b0;
            s00_axi.arready <= 1'b0;
            s00_axi.rvalid  <= 1'b0;
            s00_axi.rdata   <= '0;
        end else begin
            s00_axi.awready <= !s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid;
            s00_axi.wready  <= !s00_axi.awready && s00_axi.awvalid && s00_axi.wvalid && !s00_axi.bvalid;
            if (wr_fire) begin
                s00_axi.bvalid <= 1'b1;
            end else if (s00_axi.bvalid && s00_axi.bready) begin
                s00_axi.bvalid <= 1'b0;
            end
            s00_axi.arready <= !s00_axi.arready && s00_axi.arvalid && !s00_axi.rvalid;
            if (rd_fire) begin
                s00_axi.rvalid <= 1'b1;
                s00_axi.rdata  <= rd_mux;
            end else if (s00_axi.rvalid && s00_axi.rready) begin
                s00_axi.rvalid <= 1'b0;
            end
        end
    end

    // Register file writes, sticky MATCH and the prescaled counter engine.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            ctl_en     <= 1'b0;
            ctl_dir    <= 1'b0;
            ctl_auto   <= 1'b0;
            ctl_match  <= 1'b0;
            ctl_irq_en <= 1'b0;
            load_q     <= '0;
            cmp_q      <= '0;
            count_q    <= '0;
            presc_q    <= '0;
        end else begin
            if (ctrl_wr && s00_axi.wstrb[0]) begin
                ctl_en   <= s00_axi.wdata[0];
                ctl_dir  <= s00_axi.wdata[1];
                ctl_auto <= s00_axi.wdata[2];
            end
`ifdef AXI_COUNTER_IRQ_EN
            if (ctrl_wr && s00_axi.wstrb[1]) begin
                ctl_irq_en <= s00_axi.wdata[9];
            end
`endif
            if (wr_fire && (wr_sel == 2'd1)) begin
                load_q <= load_merged[C_CNT_WIDTH-1:0];
            end
            if (wr_fire && (wr_sel == 2'd2)) begin
                cmp_q <= cmp_merged[C_CNT_WIDTH-1:0];
            end
            // A fresh match outranks a simultaneous W1C so no event is lost.
            if (match_hit) begin
                ctl_match <= 1'b1;
            end else if (w1c) begin
                ctl_match <= 1'b0;
            end
            if (do_clr) begin
                count_q <= '0;
                presc_q <= '0;
            end else if (do_load) begin
                count_q <= load_q;
                presc_q <= '0;
            end else if (ctl_en) begin
                if (tick) begin
                    presc_q <= '0;
                    count_q <= (match_hit && ctl_auto) ? load_q : count_step;
                end else begin
                    presc_q <= presc_q + 32'd1;
                end
            end
        end
    end

`ifdef AXI_COUNTER_IRQ_EN
    // Level interrupt, one register stage behind MATCH.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            irq <= 1'b0;
        end else begin
            irq <= ctl_match && ctl_irq_en;
        end
    end
`endif

endmodule

// File: tb/tb_axi_lite_counter_slave.sv
// Bench for axi_lite_counter_slave: register vectors from a table, then counter, match and handshake sequences.
// Latency: responses awaited with per-transaction cycle budgets.
// Backpressure: bready/rready driven by the bench, held low in the B-stall sequence.
module tb_axi_lite_counter_slave;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    axi_lite_counter_slave_if bus ();
`ifdef AXI_COUNTER_IRQ_EN
    logic irq;
`endif

    axi_lite_counter_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .C_CNT_WIDTH(32),
        .C_PRESCALE(0)
    ) u_dut (
        .s00_axi_aclk(clk),
        .s00_axi_aresetn(aresetn),
        .s00_axi(bus)
`ifdef AXI_COUNTER_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        bit          is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input logic [31:0] act,
                               input logic [31:0] lo, input logic [31:0] hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h, required 0x%08h..0x%08h", name, act, lo, hi);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit          ok;
        logic [31:0] exp;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        sb_q.push_back(32'h0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.awready && bus.wready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("aw_w_ready");
        @(posedge clk);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.bvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        exp = sb_q.pop_front();
        if (ok) check($sformatf("bresp@%0h", addr), {30'b0, bus.bresp}, exp);
        else    timeout_fail("bvalid");
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok;
        data = 32'hDEAD_BEEF;
        resp = 2'b11;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.arready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout_fail("arready");
        @(posedge clk);
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            data = bus.rdata;
            resp = bus.rresp;
        end else begin
            timeout_fail("rvalid");
        end
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [3:0] addr, input logic [31:0] exp_val);
        logic [31:0] data;
        logic [31:0] exp;
        logic [1:0]  resp;
        sb_q.push_back(exp_val);
        axi_read(addr, data, resp);
        exp = sb_q.pop_front();
        check(name, data, exp);
        check({name, "_rresp"}, {30'b0, resp}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        logic [1:0]  resp;

        // Register-map vectors: {is_wr, addr, data, strb, expected read value}.
        vecs[0]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
        vecs[2]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002};
        vecs[3]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003};
        vecs[4]  = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'h5, 32'h0};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h00BB_00DD};
        vecs[6]  = '{1'b1, 4'hC, 32'h0000_1234, 4'hF, 32'h0};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0000};
        vecs[8]  = '{1'b1, 4'h0, 32'hFFFF_FEF8, 4'hF, 32'h0};
        vecs[9]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0000};
        vecs[10] = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0000};
        vecs[11] = '{1'b1, 4'h0, 32'h0000_0016, 4'hF, 32'h0};
        vecs[12] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0006};
        vecs[13] = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h00BB_00DD};
        vecs[14] = '{1'b1, 4'h0, 32'h0000_0000, 4'h0, 32'h0};
        vecs[15] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0006};
        vecs[16] = '{1'b1, 4'h0, 32'h0000_0000, 4'hF, 32'h0};
        vecs[17] = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0000};

        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata  = '0; bus.wstrb  = '0; bus.wvalid  = 1'b0;
        bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, bus.awready}, 32'h0);
        check("rst_wready",  {31'b0, bus.wready},  32'h0);
        check("rst_bvalid",  {31'b0, bus.bvalid},  32'h0);
        check("rst_arready", {31'b0, bus.arready}, 32'h0);
        check("rst_rvalid",  {31'b0, bus.rvalid},  32'h0);
        check("rst_rdata",   bus.rdata,            32'h0);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven register access.
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else               rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Free-running up count from zero, then CLR.
        axi_write(4'h0, 32'h8, 4'hF);
        axi_write(4'h0, 32'h1, 4'hF);
        repeat (10) @(negedge clk);
        axi_read(4'hC, v1, resp);
        check_range("count_up", v1, 32'd8, 32'd14);
        axi_read(4'hC, v2, resp);
        check("count_increasing", {31'b0, (v2 > v1)}, 32'h1);
        axi_write(4'h0, 32'h8, 4'hF);
        rd_check("count_clr", 4'hC, 32'h0);
        rd_check("match_after_up", 4'h0, 32'h100);
        axi_write(4'h0, 32'h100, 4'hF);
        rd_check("match_w1c", 4'h0, 32'h0);

        // Down count with auto-reload: 5,4,3,2,5,...
        axi_write(4'h4, 32'h5, 4'hF);
        axi_write(4'h8, 32'h2, 4'hF);
        axi_write(4'h0, 32'h10, 4'hF);
        rd_check("load_now", 4'hC, 32'h5);
        axi_write(4'h0, 32'h7, 4'hF);
        for (int i = 0; i < 8; i++) begin
            axi_read(4'hC, v1, resp);
            check_range($sformatf("reload_seq%0d", i), v1, 32'd2, 32'd5);
        end
        rd_check("reload_match", 4'h0, 32'h107);

        // Match every tick: simultaneous set and W1C keeps MATCH, W1C with EN=0 clears it.
        axi_write(4'h0, 32'h0, 4'hF);
        axi_write(4'h4, 32'h7, 4'hF);
        axi_write(4'h8, 32'h7, 4'hF);
        axi_write(4'h0, 32'h10, 4'hF);
        axi_write(4'h0, 32'h5, 4'hF);
        axi_write(4'h0, 32'h100, 4'hF);
        rd_check("match_set_wins", 4'h0, 32'h100);
        axi_write(4'h0, 32'h100, 4'hF);
        rd_check("match_cleared", 4'h0, 32'h0);

        // Wrap below zero when counting down without reload.
        axi_write(4'h0, 32'h8, 4'hF);
        axi_write(4'h0, 32'h3, 4'hF);
        axi_write(4'h0, 32'h0, 4'hF);
        axi_read(4'hC, v1, resp);
        check_range("wrap_down", v1, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Wrap above max when counting up.
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h0, 32'h10, 4'hF);
        rd_check("load_max", 4'hC, 32'hFFFF_FFFF);
        axi_write(4'h0, 32'h1, 4'hF);
        axi_write(4'h0, 32'h0, 4'hF);
        axi_read(4'hC, v1, resp);
        check_range("wrap_up", v1, 32'h0, 32'h10);

        // B stall: response held, second write refused, then reset drops it.
        bus.awaddr = 4'h4; bus.wdata = 32'h55; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        v1 = 32'h0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.awready) begin
                v1 = 32'h1;
                break;
            end
        end
        check("stall_first_accept", v1, 32'h1);
        @(posedge clk);
        @(negedge clk);
        bus.wdata = 32'hAA;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_bvalid%0d", i), {31'b0, bus.bvalid}, 32'h1);
            check($sformatf("stall_awready%0d", i), {31'b0, bus.awready}, 32'h0);
        end
        rd_check("stall_load", 4'h4, 32'h55);
        aresetn = 1'b0;
        @(negedge clk);
        check("rst_drops_bvalid", {31'b0, bus.bvalid}, 32'h0);
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        @(negedge clk);
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_bvalid", {31'b0, bus.bvalid}, 32'h0);
        rd_check("post_rst_ctrl",  4'h0, 32'h0);
        rd_check("post_rst_load",  4'h4, 32'h0);
        rd_check("post_rst_count", 4'hC, 32'h0);
        check("scoreboard_empty", sb_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
